// File: rtl/level_tick_scheduler.sv
// Level-dependent game tick and display refresh strobe generator.
// Also runs the start/pause/done round sequencer around the game tick.
module level_tick_scheduler #(
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned LVL0_DIV   = 100000000,
    parameter int unsigned LVL1_DIV   = 50000000,
    parameter int unsigned LVL2_DIV   = 25000000,
    parameter int unsigned TICK_LIMIT = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        pause,
    input  logic        clear,
    input  logic [1:0]  level,
    output logic        scan_tick,
    output logic        game_tick,
    output logic [15:0] tick_count,
    output logic [1:0]  cur_level,
    output logic [1:0]  state,
    output logic        done
);

    localparam int unsigned MAX01   = (LVL0_DIV > LVL1_DIV) ? LVL0_DIV : LVL1_DIV;
    localparam int unsigned MAX_DIV = (MAX01 > LVL2_DIV) ? MAX01 : LVL2_DIV;
    localparam int unsigned GW      = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;
    localparam int unsigned SW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          r_state;
    logic [SW-1:0]   r_scan_cnt;
    logic [GW-1:0]   r_game_cnt;
    logic [15:0]     r_tick_count;
    logic [1:0]      r_cur_level;
    logic            r_pause_q;
    logic            r_scan_tick;
    logic            r_game_tick;
    logic            r_done;

    logic            w_pause_rise;
    logic [1:0]      w_lvl_req;
    logic [GW-1:0]   w_div_m1;
    logic            w_period_end;
    logic            w_last_tick;
    logic            w_scan_end;

    assign w_pause_rise = pause & ~r_pause_q;
    assign w_lvl_req    = (level == 2'd3) ? 2'd2 : level;
    assign w_period_end = (r_game_cnt == w_div_m1);
    assign w_last_tick  = (r_tick_count == 16'(TICK_LIMIT - 32'd1));
    assign w_scan_end   = (r_scan_cnt == SW'(SCAN_DIV - 32'd1));

    // Terminal count of the game period for the level in effect
    always_comb begin
        w_div_m1 = GW'(LVL2_DIV - 32'd1);
        case (r_cur_level)
            2'd0:    w_div_m1 = GW'(LVL0_DIV - 32'd1);
            2'd1:    w_div_m1 = GW'(LVL1_DIV - 32'd1);
            default: w_div_m1 = GW'(LVL2_DIV - 32'd1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_scan_cnt   <= '0;
            r_game_cnt   <= '0;
            r_tick_count <= '0;
            r_cur_level  <= 2'd0;
            r_pause_q    <= 1'b0;
            r_scan_tick  <= 1'b0;
            r_game_tick  <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_pause_q   <= pause;
            r_scan_cnt  <= w_scan_end ? '0 : r_scan_cnt + SW'(1);
            r_scan_tick <= w_scan_end;
            r_game_tick <= 1'b0;
            r_done      <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state      <= S_RUN;
                        r_game_cnt   <= '0;
                        r_tick_count <= '0;
                        r_cur_level  <= w_lvl_req;
                    end
                end
                S_RUN: begin
                    if (clear) begin
                        r_state <= S_IDLE;
                    end else if (w_period_end) begin
                        // Pended level takes effect only at a period boundary
                        r_game_cnt   <= '0;
                        r_game_tick  <= 1'b1;
                        r_tick_count <= r_tick_count + 16'd1;
                        r_cur_level  <= w_lvl_req;
                        // Round end beats pause so tick_count cannot overrun the limit
                        if (w_last_tick) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else if (w_pause_rise) begin
                            r_state <= S_PAUSED;
                        end
                    end else begin
                        r_game_cnt <= r_game_cnt + GW'(1);
                        if (w_pause_rise) begin
                            r_state <= S_PAUSED;
                        end
                    end
                end
                S_PAUSED: begin
                    if (clear) begin
                        r_state <= S_IDLE;
                    end else if (w_pause_rise) begin
                        r_state <= S_RUN;
                    end
                end
                S_DONE: begin
                    if (clear) begin
                        r_state <= S_IDLE;
                    end else if (start) begin
                        r_state      <= S_RUN;
                        r_game_cnt   <= '0;
                        r_tick_count <= '0;
                        r_cur_level  <= w_lvl_req;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign scan_tick  = r_scan_tick;
    assign game_tick  = r_game_tick;
    assign tick_count = r_tick_count;
    assign cur_level  = r_cur_level;
    assign state      = r_state;
    assign done       = r_done;

endmodule

// File: tb/tb_level_tick_scheduler.sv
// Directed bench for level_tick_scheduler using small dividers.
module tb_level_tick_scheduler;

    logic        clk = 1'b0;
    logic        reset, start, pause, clear;
    logic [1:0]  level;
    logic        scan_tick, game_tick, done;
    logic [15:0] tick_count;
    logic [1:0]  cur_level, state;

    int n_cmp = 0;
    int n_bad = 0;
    int sc = 0;
    int run_acc = 0;
    int n;
    int ticks_seen;

    typedef struct {
        logic        st;
        logic [1:0]  lv;
        logic        g;
        logic [15:0] cnt;
        logic [1:0]  clv;
        logic [1:0]  s;
        logic        d;
    } vec_t;

    vec_t tbl[$];

    level_tick_scheduler #(
        .SCAN_DIV(3), .LVL0_DIV(4), .LVL1_DIV(6), .LVL2_DIV(10), .TICK_LIMIT(5)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .clear(clear),
        .level(level), .scan_tick(scan_tick), .game_tick(game_tick),
        .tick_count(tick_count), .cur_level(cur_level), .state(state), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock; the scan strobe is checked against a free-running model every cycle
    task automatic step();
        if (state == 2'd1) run_acc++;
        @(posedge clk);
        #1;
        if (reset) sc = 0;
        else sc++;
        check("scan_tick", int'(scan_tick), int'(sc != 0 && sc % 3 == 0));
    endtask

    task automatic wait_tick(input int budget, output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!game_tick && cycles < budget);
        if (!game_tick) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_tick: actual=no tick required=tick within %0d", budget);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic g, input int cnt,
                                input int s, input logic d);
        vec_t v;
        v.st = st; v.lv = 2'd0; v.g = g; v.cnt = 16'(cnt);
        v.clv = 2'd0; v.s = 2'(s); v.d = d;
        return v;
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0; level = 2'd0;
        @(posedge clk); #1;
        step();
        check("rst_state", state, 0);
        check("rst_game", game_tick, 0);
        check("rst_cnt", tick_count, 0);
        check("rst_lvl", cur_level, 0);
        check("rst_done", done, 0);
        reset = 1'b0;

        // Idle 12 cycles, then a level-0 round to DONE
        for (int i = 1; i <= 12; i++) tbl.push_back(mk(1'b0, 1'b0, 0, 0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 0, 1, 1'b0));
        for (int j = 1; j <= 23; j++)
            tbl.push_back(mk(1'b0, (j % 4 == 0 && j <= 20), (j / 4 > 5) ? 5 : j / 4,
                             (j >= 20) ? 3 : 1, (j == 20)));

        foreach (tbl[i]) begin
            start = tbl[i].st;
            level = tbl[i].lv;
            step();
            check($sformatf("v%0d_game", i), game_tick, tbl[i].g);
            check($sformatf("v%0d_cnt", i), tick_count, tbl[i].cnt);
            check($sformatf("v%0d_lvl", i), cur_level, tbl[i].clv);
            check($sformatf("v%0d_state", i), state, tbl[i].s);
            check($sformatf("v%0d_done", i), done, tbl[i].d);
        end
        start = 1'b0;

        // Level 1 restart from DONE, pause after tick 2, resume
        level = 2'd1; start = 1'b1;
        step();
        start = 1'b0;
        check("t3_state_run", state, 1);
        check("t3_cnt_zero", tick_count, 0);
        check("t3_lvl", cur_level, 1);
        wait_tick(20, n); check("t3_first_ivl", n, 6);
        wait_tick(20, n); check("t3_second_ivl", n, 6);
        check("t3_cnt2", tick_count, 2);
        run_acc = 0;
        step();
        pause = 1'b1;
        step();
        check("t3_paused", state, 2);
        ticks_seen = 0;
        for (int i = 0; i < 19; i++) begin
            step();
            ticks_seen += int'(game_tick);
        end
        pause = 1'b0;
        step();
        ticks_seen += int'(game_tick);
        check("t3_still_paused", state, 2);
        check("t3_no_ticks_paused", ticks_seen, 0);
        pause = 1'b1;
        step();
        pause = 1'b0;
        check("t3_resumed", state, 1);
        wait_tick(20, n);
        check("t3_resume_ivl", n, 4);
        check("t3_run_cycles", run_acc, 6);
        check("t3_cnt3", tick_count, 3);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("t3_clear_idle", state, 0);
        check("t3_clear_hold", tick_count, 3);

        // Level change mid-period applies at the wrap
        level = 2'd0; start = 1'b1;
        step();
        start = 1'b0;
        check("t4_lvl0", cur_level, 0);
        step(); step();
        level = 2'd2;
        step();
        check("t4_lvl_pended", cur_level, 0);
        check("t4_no_tick_yet", game_tick, 0);
        step();
        check("t4_tick_at_4", game_tick, 1);
        check("t4_lvl_applied", cur_level, 2);
        wait_tick(20, n);
        check("t4_ivl10", n, 10);
        check("t4_cnt2", tick_count, 2);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("t4_idle", state, 0);

        // Level 3 maps to 2; clear on a wrap suppresses the tick
        level = 2'd3; start = 1'b1;
        step();
        start = 1'b0;
        check("t5_lvl_map", cur_level, 2);
        wait_tick(20, n);
        check("t5_ivl10", n, 10);
        ticks_seen = 0;
        for (int i = 0; i < 9; i++) begin
            step();
            ticks_seen += int'(game_tick);
        end
        check("t5_no_early_tick", ticks_seen, 0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("t5_clear_game", game_tick, 0);
        check("t5_clear_done", done, 0);
        check("t5_clear_state", state, 0);
        check("t5_clear_hold", tick_count, 1);

        // Reset while PAUSED
        level = 2'd1; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_tick(20, n);
            check($sformatf("t6_ivl%0d", i), n, 6);
        end
        pause = 1'b1;
        step();
        pause = 1'b0;
        check("t6_paused", state, 2);
        check("t6_cnt3", tick_count, 3);
        check("t6_lvl1", cur_level, 1);
        step();
        reset = 1'b1;
        step();
        check("t6_rst_state", state, 0);
        check("t6_rst_cnt", tick_count, 0);
        check("t6_rst_lvl", cur_level, 0);
        check("t6_rst_game", game_tick, 0);
        check("t6_rst_done", done, 0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t6_post_state", state, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
